// File: rtl/mmio_uart_pkg.sv
// ---------------------------------------------------------------------------
// mmio_uart_pkg
// Shared types and constants for the memory-mapped UART transmitter.
//   - uart_state_e : transmit FSM states
//   - OFF_*        : register word offsets (addr[3:2]) inside the window
//   - STAT_*       : bit positions inside the STATUS register
//   - sat_level    : clamps a FIFO fill level to the 4-bit STATUS field
//   - even_parity  : XOR of a data byte, used as the optional parity bit
// ---------------------------------------------------------------------------
package mmio_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_PAR     = 4;
    localparam int STAT_LVL_LSB = 8;
    localparam int STAT_LVL_MSB = 11;

    // Level field is only 4 bits wide; deeper FIFOs report 15 when fuller.
    function automatic logic [3:0] sat_level(input logic [31:0] lvl);
        return (lvl > 32'd15) ? 4'd15 : lvl[3:0];
    endfunction

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a fill counter.
//   clk, rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   push/wdata : write one entry; ignored when full
//   pop/rdata  : rdata always shows the head entry; pop ignored when empty
//   full/empty : status flags derived from the fill count
//   level      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == LW'(DEPTH));
    assign empty     = (r_count == LW'(0));
    assign level     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    // Full/empty are judged on the current count, so a push into a full
    // FIFO is dropped even when a pop happens on the same edge.
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    // Pointer and fill-count bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= PW'(0);
            r_rd_ptr <= PW'(0);
            r_count  <= LW'(0);
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are never read while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped UART transmitter (8N1, LSB first) on the core data port.
// Register window (addr[31:4] == BASE_ADDR[31:4], word offset addr[3:2]):
//   0 TXDATA  : store pushes dataW[7:0] into the TX FIFO; reads 0
//   1 STATUS  : [0] full [1] empty [2] busy [3] overflow (sticky, store
//               with dataW[3]=1 clears) [4] parity present [11:8] level
//   2 BAUDDIV : clocks per bit, bits [15:0]; 0 behaves as 1
//   3         : reads 0, stores ignored
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   addr, dataW   : byte address and store data from the core
//   funct3        : access size (unused, every store is taken as a word)
//   MemRW         : 1 = store this cycle
//   dataR         : combinational load data (0 outside the window)
//   tx            : registered UART line, idles high
//   irq           : registered, high while FIFO empty and FSM idle
// Build option: define MMIO_UART_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit.
// ---------------------------------------------------------------------------
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] dataW,
    input  logic [2:0]  funct3,
    input  logic        MemRW,
    output logic [31:0] dataR,
    output logic        tx,
    output logic        irq
);

    localparam int LW = $clog2(DEPTH) + 1;

    uart_state_e   r_state;
    logic [15:0]   r_cnt;
    logic [15:0]   r_baud;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitn;
    logic          r_par;
    logic          r_tx;
    logic          r_irq;
    logic          r_ovf;

    logic          w_hit;
    logic [1:0]    w_off;
    logic          w_wr_tx;
    logic          w_wr_stat;
    logic          w_wr_baud;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic [7:0]    w_rdata;
    logic [15:0]   w_div;
    logic [15:0]   w_reload;
    logic          w_par_present;
    logic          w_unused;

    assign w_hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off     = addr[3:2];
    assign w_wr_tx   = w_hit & MemRW & (w_off == OFF_TXDATA);
    assign w_wr_stat = w_hit & MemRW & (w_off == OFF_STATUS);
    assign w_wr_baud = w_hit & MemRW & (w_off == OFF_BAUDDIV);
    assign w_push_ok = w_wr_tx & ~w_full;
    assign w_unused  = ^{funct3, addr[1:0], dataW[31:16]};

    // Bit timer reload always takes the live divider, so a BAUDDIV write
    // only takes effect at the next bit boundary.
    assign w_div    = (r_baud == 16'd0) ? 16'd1 : r_baud;
    assign w_reload = w_div - 16'd1;

    // Pop from IDLE, or on the final stop-bit edge for back-to-back frames.
    assign w_pop = ~w_empty & ((r_state == IDLE) |
                               ((r_state == STOP) & (r_cnt == 16'd0)));

`ifdef MMIO_UART_PARITY_EN
    assign w_par_present = 1'b1;
`else
    assign w_par_present = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_wr_tx),
        .pop   (w_pop),
        .wdata (dataW[7:0]),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // Sticky overflow flag and the baud divider register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_baud <= DEFAULT_DIV;
        end else begin
            if (w_wr_tx && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat && dataW[STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_baud) begin
                r_baud <= dataW[15:0];
            end
        end
    end

    // Transmit FSM; tx and irq are registered alongside the state so they
    // always describe the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_shift <= 8'd0;
            r_bitn  <= 3'd0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_irq   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state <= START;
                        r_tx    <= 1'b0;
                        r_cnt   <= w_reload;
                        r_shift <= w_rdata;
                        r_par   <= even_parity(w_rdata);
                        r_irq   <= 1'b0;
                    end else begin
                        r_tx  <= 1'b1;
                        // A byte landing in the empty FIFO this edge means
                        // the block is no longer done.
                        r_irq <= ~w_push_ok;
                    end
                end
                START: begin
                    r_irq <= 1'b0;
                    if (r_cnt == 16'd0) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                        r_bitn  <= 3'd0;
                        r_cnt   <= w_reload;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                DATA: begin
                    r_irq <= 1'b0;
                    if (r_cnt == 16'd0) begin
                        r_cnt <= w_reload;
                        if (r_bitn == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_par;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                            r_bitn  <= r_bitn + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                PARITY: begin
                    r_irq <= 1'b0;
                    if (r_cnt == 16'd0) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                        r_cnt   <= w_reload;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == 16'd0) begin
                        if (w_pop) begin
                            r_state <= START;
                            r_tx    <= 1'b0;
                            r_cnt   <= w_reload;
                            r_shift <= w_rdata;
                            r_par   <= even_parity(w_rdata);
                            r_irq   <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                            r_irq   <= ~w_push_ok;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                        r_irq <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_irq   <= 1'b1;
                end
            endcase
        end
    end

    assign tx  = r_tx;
    assign irq = r_irq;

    // Load data mux; TXDATA and offset 3 read as zero.
    always_comb begin
        dataR = 32'd0;
        if (w_hit) begin
            case (w_off)
                OFF_STATUS: begin
                    dataR[STAT_FULL]  = w_full;
                    dataR[STAT_EMPTY] = w_empty;
                    dataR[STAT_BUSY]  = (r_state != IDLE);
                    dataR[STAT_OVF]   = r_ovf;
                    dataR[STAT_PAR]   = w_par_present;
                    dataR[STAT_LVL_MSB:STAT_LVL_LSB] = sat_level(32'(w_level));
                end
                OFF_BAUDDIV: dataR = {16'd0, r_baud};
                default:     dataR = 32'd0;
            endcase
        end else begin
            dataR = 32'd0;
        end
    end

endmodule
